// File: rtl/chore_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Optional feature macro used by fetch_ctrl: CHORE_FETCH_PERF_EN.
package chore_fetch_pkg;

  localparam int XLEN_DEF          = 64;
  localparam int IM_DEPTH_DEF      = 2048;
  localparam int IM_ADDR_WIDTH_DEF = $clog2(IM_DEPTH_DEF);
  localparam int IM_DATA_WIDTH_DEF = 32;
  localparam int FQ_DEPTH_DEF      = 2;

  // Canonical RISC-V NOP (addi x0, x0, 0), shown to ID while nothing is queued.
  localparam logic [31:0] CHORE_NOP = 32'h00000013;

  typedef enum logic {
    FS_RUN   = 1'b0,
    FS_FAULT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  // Instruction addresses must be word aligned; only the low two bits matter.
  function automatic logic isAligned(input logic [1:0] pcLow);
    return pcLow == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bus bundle between the fetch sequencer and its environment:
// instruction-memory port, EX redirect request, ID handshake and fault flag.
// master = fetch_ctrl side, slave = memory/pipeline side.
interface fetch_ctrl_if
  import chore_fetch_pkg::*;
#(
  parameter int XLEN          = XLEN_DEF,
  parameter int IM_ADDR_WIDTH = IM_ADDR_WIDTH_DEF,
  parameter int IM_DATA_WIDTH = IM_DATA_WIDTH_DEF
);

  logic [IM_ADDR_WIDTH-1:0]   o_im_addr;
  logic [IM_DATA_WIDTH/8-1:0] o_im_wen;
  logic [IM_DATA_WIDTH-1:0]   i_im_rdata;
  logic                       i_redir_valid;
  logic [XLEN-1:0]            i_redir_pc;
  logic                       o_id_valid;
  logic                       i_id_ready;
  logic [IM_DATA_WIDTH-1:0]   o_id_instr;
  logic [XLEN-1:0]            o_id_pc;
  logic                       o_fault;

  modport master (
    output o_im_addr, o_im_wen,
    input  i_im_rdata,
    input  i_redir_valid, i_redir_pc,
    output o_id_valid,
    input  i_id_ready,
    output o_id_instr, o_id_pc, o_fault
  );

  modport slave (
    input  o_im_addr, o_im_wen,
    output i_im_rdata,
    output i_redir_valid, i_redir_pc,
    input  o_id_valid,
    output i_id_ready,
    input  o_id_instr, o_id_pc, o_fault
  );

endinterface

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetched (pc, instr) entries.
// Flush wins over push and pop; simultaneous push and pop keeps the count.
module fetch_queue
  import chore_fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  fq_entry_t                pushData_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output fq_entry_t                head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  fq_entry_t        storage_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush, doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign head_o  = storage_q[rdPtr_q];

  assign doPop  = pop_i & ~empty_o & ~flush_i;
  assign doPush = push_i & ~flush_i & (~full_o | doPop);

  // Next pointer/count values; a flush empties the queue outright.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
      unique case ({doPush, doPop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset: empty_o gates every read of it.
  always_ff @(posedge clk) begin
    if (doPush) storage_q[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the 1-cycle-latency
// instruction memory, buffers returned words with their PC and hands them
// to ID with valid/ready. EX redirects flush buffered and in-flight fetches;
// a misaligned redirect parks the unit in FAULT until an aligned redirect.
// Optional feature macro: CHORE_FETCH_PERF_EN adds fetched/stall counters.
module fetch_ctrl
  import chore_fetch_pkg::*;
#(
  parameter int              XLEN          = XLEN_DEF,
  parameter int              IM_DEPTH      = IM_DEPTH_DEF,
  parameter int              IM_ADDR_WIDTH = $clog2(IM_DEPTH),
  parameter int              IM_DATA_WIDTH = IM_DATA_WIDTH_DEF,
  parameter logic [XLEN-1:0] RESET_PC      = '0,
  parameter int              FQ_DEPTH      = FQ_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_ctrl_if.master bus
`ifdef CHORE_FETCH_PERF_EN
  ,
  output logic [31:0]  o_perf_fetched,
  output logic [31:0]  o_perf_stall
`endif
);

  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;
  localparam int OCC_W = CNT_W + 1;

  fetch_state_e     state_q, state_d;
  logic             fault_q;
  logic [XLEN-1:0]  fetchPc_q, fetchPc_d;
  logic             inflight_q, inflight_d;
  logic [XLEN-1:0]  inflightPc_q, inflightPc_d;

  fq_entry_t        qHead;
  fq_entry_t        qPushData;
  logic [CNT_W-1:0] qCount;
  logic             qFull, qEmpty;
  logic             qPush;

  logic             redirAligned, redirMisaligned;
  logic             pop;
  logic [OCC_W-1:0] occupancy;
  logic             issueSeq, issue;

  assign redirAligned    = bus.i_redir_valid &  isAligned(bus.i_redir_pc[1:0]);
  assign redirMisaligned = bus.i_redir_valid & ~isAligned(bus.i_redir_pc[1:0]);

  assign pop = bus.o_id_valid & bus.i_id_ready;

  // Credits count the in-flight word too, so a full queue can never overflow.
  assign occupancy = OCC_W'(qCount) + OCC_W'(inflight_q) - OCC_W'(pop);
  assign issueSeq  = (state_q == FS_RUN) & ~bus.i_redir_valid &
                     ~(qFull & ~pop) & (occupancy < OCC_W'(FQ_DEPTH));
  assign issue     = issueSeq | redirAligned;

  // A redirect read is sent to memory in the same cycle it is requested.
  assign bus.o_im_addr = redirAligned ? bus.i_redir_pc[2 +: IM_ADDR_WIDTH]
                                      : fetchPc_q[2 +: IM_ADDR_WIDTH];
  assign bus.o_im_wen  = '0;

  // Any redirect kills the word returning this cycle, since it is old-path.
  assign qPush     = inflight_q & ~bus.i_redir_valid;
  assign qPushData = '{pc: inflightPc_q, instr: bus.i_im_rdata};

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (qPush),
    .pushData_i (qPushData),
    .pop_i      (pop),
    .flush_i    (bus.i_redir_valid),
    .head_o     (qHead),
    .count_o    (qCount),
    .full_o     (qFull),
    .empty_o    (qEmpty)
  );

  assign bus.o_id_valid = ~qEmpty;
  assign bus.o_id_instr = qEmpty ? CHORE_NOP : qHead.instr;
  assign bus.o_id_pc    = qEmpty ? RESET_PC  : qHead.pc;
  assign bus.o_fault    = fault_q;

  // Next PC and in-flight tracking; a redirect overrides sequential fetch.
  always_comb begin
    fetchPc_d    = fetchPc_q;
    inflightPc_d = inflightPc_q;
    inflight_d   = issue;
    if (redirAligned) begin
      fetchPc_d    = bus.i_redir_pc + XLEN'(4);
      inflightPc_d = bus.i_redir_pc;
    end else if (issueSeq) begin
      fetchPc_d    = fetchPc_q + XLEN'(4);
      inflightPc_d = fetchPc_q;
    end
  end

  // RUN/FAULT transitions, driven only by redirects.
  always_comb begin
    state_d = state_q;
    if (redirAligned)         state_d = FS_RUN;
    else if (redirMisaligned) state_d = FS_FAULT;
  end

  // FSM state with its registered fault flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FS_RUN;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= (state_d == FS_FAULT);
    end
  end

  // PC and in-flight read registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchPc_q    <= RESET_PC;
      inflight_q   <= 1'b0;
      inflightPc_q <= RESET_PC;
    end else begin
      fetchPc_q    <= fetchPc_d;
      inflight_q   <= inflight_d;
      inflightPc_q <= inflightPc_d;
    end
  end

`ifdef CHORE_FETCH_PERF_EN
  logic [31:0] perfFetched_q;
  logic [31:0] perfStall_q;

  // Accepted-instruction and fetch-stall counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perfFetched_q <= '0;
      perfStall_q   <= '0;
    end else begin
      if (pop) perfFetched_q <= perfFetched_q + 32'd1;
      if ((state_q == FS_RUN) & ~issue & ~bus.i_redir_valid)
        perfStall_q <= perfStall_q + 32'd1;
    end
  end

  assign o_perf_fetched = perfFetched_q;
  assign o_perf_stall   = perfStall_q;
`else
  // Performance counters are compiled out in this build.
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl: sequential fetch, ID
// back-pressure, redirects (including PC wrap), misaligned-redirect fault,
// asynchronous reset mid-stream and, when CHORE_FETCH_PERF_EN is defined,
// the performance counters.
module tb_fetch_ctrl;
  import chore_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int testsRun = 0;
  int testsFailed = 0;
  logic [31:0] imem [2048];

`ifdef CHORE_FETCH_PERF_EN
  logic [31:0] perfFetched;
  logic [31:0] perfStall;
`endif

  always #5 clk = ~clk;

  fetch_ctrl_if bus ();

  fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus)
`ifdef CHORE_FETCH_PERF_EN
    ,
    .o_perf_fetched (perfFetched),
    .o_perf_stall   (perfStall)
`endif
  );

  // Synchronous single-port memory model with one cycle read latency.
  always @(posedge clk) bus.i_im_rdata <= imem[bus.o_im_addr];

  function automatic logic [31:0] memWord(input int idx);
    return 32'hA500_0000 + 32'(idx);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkId(input string tag, input logic [31:0] instr, input logic [63:0] pc);
    checkOutput({tag, ".valid"}, 64'(bus.o_id_valid), 64'd1);
    checkOutput({tag, ".instr"}, 64'(bus.o_id_instr), 64'(instr));
    checkOutput({tag, ".pc"}, bus.o_id_pc, pc);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic rv, input logic [63:0] rpc, input logic rdy);
    bus.i_redir_valid = rv;
    bus.i_redir_pc    = rpc;
    bus.i_id_ready    = rdy;
    #1;
  endtask

  // Holds reset across one edge; returns inside cycle 0 after release.
  task automatic applyReset(input logic rdy);
    rst_n = 1'b0;
    applyStimulus(1'b0, 64'h0, rdy);
    nextCycle();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 2048; i++) imem[i] = memWord(i);
    bus.i_redir_valid = 1'b0;
    bus.i_redir_pc    = 64'h0;
    bus.i_id_ready    = 1'b0;

    // Test 1: reset values, then sequential fetch with ID always ready.
    applyReset(1'b1);
    checkOutput("t1.reset.valid", 64'(bus.o_id_valid), 64'd0);
    checkOutput("t1.reset.instr", 64'(bus.o_id_instr), 64'h13);
    checkOutput("t1.reset.pc", bus.o_id_pc, 64'h0);
    checkOutput("t1.reset.fault", 64'(bus.o_fault), 64'd0);
    checkOutput("t1.reset.wen", 64'(bus.o_im_wen), 64'd0);
    checkOutput("t1.c0.addr", 64'(bus.o_im_addr), 64'd0);
    nextCycle(); applyStimulus(1'b0, 64'h0, 1'b1);
    checkOutput("t1.c1.addr", 64'(bus.o_im_addr), 64'd1);
    checkOutput("t1.c1.valid", 64'(bus.o_id_valid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      nextCycle(); applyStimulus(1'b0, 64'h0, 1'b1);
      checkOutput($sformatf("t1.c%0d.addr", k + 2), 64'(bus.o_im_addr), 64'(k + 2));
      checkId($sformatf("t1.c%0d", k + 2), memWord(k), 64'(4 * k));
    end

    // Test 2: ID stalls for five cycles after the first valid word.
    applyReset(1'b1);
    nextCycle(); applyStimulus(1'b0, 64'h0, 1'b1);
    for (int c = 2; c <= 6; c++) begin
      nextCycle(); applyStimulus(1'b0, 64'h0, 1'b0);
      checkId($sformatf("t2.c%0d.hold", c), memWord(0), 64'h0);
      checkOutput($sformatf("t2.c%0d.addr", c), 64'(bus.o_im_addr), 64'd2);
    end
    nextCycle(); applyStimulus(1'b0, 64'h0, 1'b1);
    checkId("t2.c7", memWord(0), 64'h0);
    checkOutput("t2.c7.addr", 64'(bus.o_im_addr), 64'd2);
    nextCycle(); applyStimulus(1'b0, 64'h0, 1'b1);
    checkId("t2.c8", memWord(1), 64'h4);
    nextCycle(); applyStimulus(1'b0, 64'h0, 1'b1);
    checkId("t2.c9", memWord(2), 64'h8);
    nextCycle(); applyStimulus(1'b0, 64'h0, 1'b1);
    checkId("t2.c10", memWord(3), 64'hC);

    // Test 3: redirect to 0x40 while B is returning, then a wrapping redirect.
    applyReset(1'b1);
    nextCycle(); applyStimulus(1'b0, 64'h0, 1'b1);
    nextCycle(); applyStimulus(1'b1, 64'h40, 1'b1);
    checkOutput("t3.c2.addr", 64'(bus.o_im_addr), 64'h10);
    checkId("t3.c2", memWord(0), 64'h0);
    nextCycle(); applyStimulus(1'b0, 64'h0, 1'b1);
    checkOutput("t3.c3.valid", 64'(bus.o_id_valid), 64'd0);
    checkOutput("t3.c3.addr", 64'(bus.o_im_addr), 64'h11);
    nextCycle(); applyStimulus(1'b0, 64'h0, 1'b1);
    checkId("t3.c4", memWord(16), 64'h40);
    nextCycle(); applyStimulus(1'b0, 64'h0, 1'b1);
    checkId("t3.c5", memWord(17), 64'h44);
    nextCycle(); applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
    checkOutput("t3.wrap.addr0", 64'(bus.o_im_addr), 64'h7FF);
    nextCycle(); applyStimulus(1'b0, 64'h0, 1'b1);
    checkOutput("t3.wrap.valid", 64'(bus.o_id_valid), 64'd0);
    checkOutput("t3.wrap.addr1", 64'(bus.o_im_addr), 64'h0);
    nextCycle(); applyStimulus(1'b0, 64'h0, 1'b1);
    checkId("t3.wrap.top", memWord(2047), 64'hFFFF_FFFF_FFFF_FFFC);
    nextCycle(); applyStimulus(1'b0, 64'h0, 1'b1);
    checkId("t3.wrap.zero", memWord(0), 64'h0);

    // Test 4: misaligned redirect faults; aligned redirect recovers.
    applyReset(1'b1);
    nextCycle(); applyStimulus(1'b0, 64'h0, 1'b1);
    nextCycle(); applyStimulus(1'b1, 64'h42, 1'b1);
    checkOutput("t4.c2.fault", 64'(bus.o_fault), 64'd0);
    for (int c = 3; c <= 12; c++) begin
      nextCycle(); applyStimulus(1'b0, 64'h0, 1'b1);
      checkOutput($sformatf("t4.c%0d.fault", c), 64'(bus.o_fault), 64'd1);
      checkOutput($sformatf("t4.c%0d.valid", c), 64'(bus.o_id_valid), 64'd0);
      checkOutput($sformatf("t4.c%0d.addr", c), 64'(bus.o_im_addr), 64'd2);
    end
    nextCycle(); applyStimulus(1'b1, 64'h80, 1'b1);
    checkOutput("t4.c13.addr", 64'(bus.o_im_addr), 64'h20);
    checkOutput("t4.c13.fault", 64'(bus.o_fault), 64'd1);
    nextCycle(); applyStimulus(1'b0, 64'h0, 1'b1);
    checkOutput("t4.c14.fault", 64'(bus.o_fault), 64'd0);
    checkOutput("t4.c14.valid", 64'(bus.o_id_valid), 64'd0);
    nextCycle(); applyStimulus(1'b0, 64'h0, 1'b1);
    checkId("t4.c15", memWord(32), 64'h80);

    // Test 5: asynchronous reset with a full queue, then refetch from 0.
    applyReset(1'b0);
    for (int c = 1; c <= 4; c++) begin
      nextCycle(); applyStimulus(1'b0, 64'h0, 1'b0);
    end
    checkId("t5.full", memWord(0), 64'h0);
    checkOutput("t5.full.addr", 64'(bus.o_im_addr), 64'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("t5.async.valid", 64'(bus.o_id_valid), 64'd0);
    checkOutput("t5.async.instr", 64'(bus.o_id_instr), 64'h13);
    checkOutput("t5.async.pc", bus.o_id_pc, 64'h0);
    checkOutput("t5.async.addr", 64'(bus.o_im_addr), 64'd0);
    checkOutput("t5.async.fault", 64'(bus.o_fault), 64'd0);
    applyReset(1'b1);
    nextCycle(); applyStimulus(1'b0, 64'h0, 1'b1);
    nextCycle(); applyStimulus(1'b0, 64'h0, 1'b1);
    checkId("t5.refetch0", memWord(0), 64'h0);
    nextCycle(); applyStimulus(1'b0, 64'h0, 1'b1);
    checkId("t5.refetch1", memWord(1), 64'h4);

`ifdef CHORE_FETCH_PERF_EN
    // Test 6: three stall cycles then twenty accepted pops.
    applyReset(1'b1);
    nextCycle(); applyStimulus(1'b0, 64'h0, 1'b1);
    for (int c = 2; c <= 4; c++) begin
      nextCycle(); applyStimulus(1'b0, 64'h0, 1'b0);
    end
    for (int c = 5; c <= 24; c++) begin
      nextCycle(); applyStimulus(1'b0, 64'h0, 1'b1);
    end
    nextCycle(); applyStimulus(1'b0, 64'h0, 1'b0);
    checkOutput("t6.fetched", 64'(perfFetched), 64'd20);
    checkOutput("t6.stall", 64'(perfStall), 64'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
